// File: rtl/ppi_control_register.sv
// ---------------------------------------------------------------------------
// ppi_control_register
//
// Control-word register of an 8255-style programmable peripheral interface.
// Captures the control word written to address 3, holds it for the port
// blocks and decodes it into group mode / direction fields. Words with
// DATA[7]=0 are bit-set/reset (BSR) commands for port C. When BSR support is
// built in, they produce a one-cycle pulse and leave the stored word unchanged.
//
// Build option:
//   PPI_CTRL_BSR_EN  defined   -> BSR words decoded into bsr_valid/bit/value
//                    undefined -> BSR words ignored, BSR outputs tied to 0
//
// Parameters:
//   RESET_WORD        control word loaded on reset (mode 0, all ports input)
//
// Ports:
//   clk               system clock, rising edge
//   rst_n             asynchronous active-low reset
//   A[1:0]            register select, 2'b11 = control register
//   WRITE             write strobe, active-low
//   READ              read strobe, active-low
//   DATA[7:0]         CPU data bus
//   Control_Register  currently held control word
//   grp_a_mode[1:0]   group A mode      (Control_Register[6:5])
//   port_a_in         port A input      (Control_Register[4])
//   port_cu_in        PC7..4 input      (Control_Register[3])
//   grp_b_mode        group B mode      (Control_Register[2])
//   port_b_in         port B input      (Control_Register[1])
//   port_cl_in        PC3..0 input      (Control_Register[0])
//   bsr_valid         one-cycle pulse per accepted BSR word
//   bsr_bit[2:0]      port C bit index of the last BSR word
//   bsr_value         set (1) / reset (0) of the last BSR word
//
// Bus handshake: a write is taken on the first rising clk edge at which
// A==3, WRITE is low and READ is high. Holding that condition produces no
// further writes; it must drop for at least one clk before another write.
// ---------------------------------------------------------------------------
module ppi_control_register #(
    parameter logic [7:0] RESET_WORD = 8'h9B
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] A,
    input  logic       WRITE,
    input  logic       READ,
    input  logic [7:0] DATA,
    output logic [7:0] Control_Register,
    output logic [1:0] grp_a_mode,
    output logic       port_a_in,
    output logic       port_cu_in,
    output logic       grp_b_mode,
    output logic       port_b_in,
    output logic       port_cl_in,
    output logic       bsr_valid,
    output logic [2:0] bsr_bit,
    output logic       bsr_value
);

    logic [7:0] r_ctrl;
    logic       r_wr_sel_d;
    logic       w_wr_sel;
    logic       w_accept;

    // Both strobes low is an illegal bus state: READ must be high to write.
    assign w_wr_sel = (A == 2'b11) && !WRITE && READ;

    // Edge detect on the select: only the first clk edge of a strobe counts.
    assign w_accept = w_wr_sel && !r_wr_sel_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_sel_d <= 1'b0;
        end else begin
            r_wr_sel_d <= w_wr_sel;
        end
    end

    // Mode-set words (DATA[7]=1) replace the held control word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= RESET_WORD;
        end else if (w_accept && DATA[7]) begin
            r_ctrl <= DATA;
        end
    end

`ifdef PPI_CTRL_BSR_EN
    logic       r_bsr_valid;
    logic [2:0] r_bsr_bit;
    logic       r_bsr_value;

    // BSR words pulse bsr_valid for one cycle; bit/value hold until the
    // next BSR word. DATA[6:4] carry no meaning in a BSR word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bsr_valid <= 1'b0;
            r_bsr_bit   <= 3'd0;
            r_bsr_value <= 1'b0;
        end else begin
            r_bsr_valid <= 1'b0;
            if (w_accept && !DATA[7]) begin
                r_bsr_valid <= 1'b1;
                r_bsr_bit   <= DATA[3:1];
                r_bsr_value <= DATA[0];
            end
        end
    end

    assign bsr_valid = r_bsr_valid;
    assign bsr_bit   = r_bsr_bit;
    assign bsr_value = r_bsr_value;
`else
    assign bsr_valid = 1'b0;
    assign bsr_bit   = 3'd0;
    assign bsr_value = 1'b0;
`endif

    assign Control_Register = r_ctrl;
    assign grp_a_mode       = r_ctrl[6:5];
    assign port_a_in        = r_ctrl[4];
    assign port_cu_in       = r_ctrl[3];
    assign grp_b_mode       = r_ctrl[2];
    assign port_b_in        = r_ctrl[1];
    assign port_cl_in       = r_ctrl[0];

endmodule

// File: tb/tb_ppi_control_register.sv
module tb_ppi_control_register;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [1:0] A;
    logic       WRITE;
    logic       READ;
    logic [7:0] DATA;
    logic [7:0] Control_Register;
    logic [1:0] grp_a_mode;
    logic       port_a_in;
    logic       port_cu_in;
    logic       grp_b_mode;
    logic       port_b_in;
    logic       port_cl_in;
    logic       bsr_valid;
    logic [2:0] bsr_bit;
    logic       bsr_value;

    int checks;
    int errors;

    // {grp_a_mode, port_a_in, port_cu_in, grp_b_mode, port_b_in, port_cl_in}
    logic [6:0] dec;
    assign dec = {grp_a_mode, port_a_in, port_cu_in, grp_b_mode, port_b_in, port_cl_in};

`ifdef PPI_CTRL_BSR_EN
    localparam bit BSR_ON = 1'b1;
`else
    localparam bit BSR_ON = 1'b0;
`endif

    ppi_control_register dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .A                (A),
        .WRITE            (WRITE),
        .READ             (READ),
        .DATA             (DATA),
        .Control_Register (Control_Register),
        .grp_a_mode       (grp_a_mode),
        .port_a_in        (port_a_in),
        .port_cu_in       (port_cu_in),
        .grp_b_mode       (grp_b_mode),
        .port_b_in        (port_b_in),
        .port_cl_in       (port_cl_in),
        .bsr_valid        (bsr_valid),
        .bsr_bit          (bsr_bit),
        .bsr_value        (bsr_value)
    );

    // Clock / reset block: the clock only runs once clk_en is raised.
    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    // Driver tasks
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        A     = 2'b00;
        WRITE = 1'b1;
        READ  = 1'b1;
    endtask

    task automatic bus_write(input logic [7:0] d);
        A     = 2'b11;
        READ  = 1'b1;
        WRITE = 1'b0;
        DATA  = d;
    endtask

    task automatic test_reset();
        clk_en = 1'b0;
        rst_n  = 1'b1;
        bus_idle();
        DATA   = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (Control_Register !== 8'h9B) begin
            errors++;
            $display("FAIL reset_ctrl: got %h expected 9b", Control_Register);
        end
        checks++;
        if (dec !== 7'b00_1_1_0_1_1) begin
            errors++;
            $display("FAIL reset_decode: got %b expected 0011011", dec);
        end
        checks++;
        if ({bsr_valid, bsr_bit, bsr_value} !== 5'b0) begin
            errors++;
            $display("FAIL reset_bsr: got %b expected 00000", {bsr_valid, bsr_bit, bsr_value});
        end
        clk_en = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        checks++;
        if (Control_Register !== 8'h9B) begin
            errors++;
            $display("FAIL reset_idle_hold: got %h expected 9b", Control_Register);
        end
    endtask

    task automatic test_mode_write();
        bus_write(8'h80);
        tick(1);
        checks++;
        if (Control_Register !== 8'h80) begin
            errors++;
            $display("FAIL mode_write: got %h expected 80", Control_Register);
        end
        checks++;
        if (dec !== 7'b0000000) begin
            errors++;
            $display("FAIL mode_decode_80: got %b expected 0000000", dec);
        end
        DATA = 8'hA4;
        tick(5);
        checks++;
        if (Control_Register !== 8'h80) begin
            errors++;
            $display("FAIL held_strobe: got %h expected 80", Control_Register);
        end
        bus_idle();
        tick(1);
    endtask

    task automatic test_bsr();
        bus_write(8'h0E);
        tick(1);
        checks++;
        if (Control_Register !== 8'h80) begin
            errors++;
            $display("FAIL bsr_ctrl_unchanged: got %h expected 80", Control_Register);
        end
        checks++;
        if (bsr_valid !== BSR_ON) begin
            errors++;
            $display("FAIL bsr_pulse: got %b expected %b", bsr_valid, BSR_ON);
        end
        checks++;
        if ({bsr_bit, bsr_value} !== (BSR_ON ? 4'b111_0 : 4'b000_0)) begin
            errors++;
            $display("FAIL bsr_fields: got %b expected %b", {bsr_bit, bsr_value},
                     (BSR_ON ? 4'b111_0 : 4'b000_0));
        end
        tick(1);
        checks++;
        if (bsr_valid !== 1'b0) begin
            errors++;
            $display("FAIL bsr_one_cycle: got %b expected 0", bsr_valid);
        end
        checks++;
        if (bsr_bit !== (BSR_ON ? 3'd7 : 3'd0)) begin
            errors++;
            $display("FAIL bsr_bit_hold: got %0d expected %0d", bsr_bit, (BSR_ON ? 7 : 0));
        end
        bus_idle();
        tick(1);
        // 0111_1011: bit 5, set; DATA[6:4] ignored
        bus_write(8'h7B);
        tick(1);
        checks++;
        if ({bsr_valid, bsr_bit, bsr_value} !== (BSR_ON ? 5'b1_101_1 : 5'b0)) begin
            errors++;
            $display("FAIL bsr_set_bit5: got %b expected %b", {bsr_valid, bsr_bit, bsr_value},
                     (BSR_ON ? 5'b1_101_1 : 5'b0));
        end
        checks++;
        if (Control_Register !== 8'h80) begin
            errors++;
            $display("FAIL bsr2_ctrl_unchanged: got %h expected 80", Control_Register);
        end
        bus_idle();
        tick(1);
    endtask

    task automatic test_gating();
        A = 2'b10; READ = 1'b1; WRITE = 1'b0; DATA = 8'd16;
        tick(2);
        checks++;
        if (Control_Register !== 8'h80) begin
            errors++;
            $display("FAIL gate_addr2: got %h expected 80", Control_Register);
        end
        bus_idle();
        tick(1);
        A = 2'b00; READ = 1'b0; WRITE = 1'b0; DATA = 8'h9B;
        tick(2);
        checks++;
        if (Control_Register !== 8'h80) begin
            errors++;
            $display("FAIL gate_addr0_both: got %h expected 80", Control_Register);
        end
        bus_idle();
        tick(1);
        A = 2'b11; READ = 1'b0; WRITE = 1'b0; DATA = 8'h9B;
        tick(2);
        checks++;
        if (Control_Register !== 8'h80) begin
            errors++;
            $display("FAIL gate_both_strobes: got %h expected 80", Control_Register);
        end
        DATA = 8'h0F;
        tick(1);
        checks++;
        if (bsr_valid !== 1'b0) begin
            errors++;
            $display("FAIL gate_both_bsr: got %b expected 0", bsr_valid);
        end
        bus_idle();
        tick(1);
        A = 2'b11; READ = 1'b0; WRITE = 1'b1; DATA = 8'hFF;
        tick(2);
        checks++;
        if (Control_Register !== 8'h80) begin
            errors++;
            $display("FAIL gate_read_only: got %h expected 80", Control_Register);
        end
        bus_idle();
        tick(1);
    endtask

    task automatic test_back_to_back();
        bus_write(8'h9B);
        tick(1);
        checks++;
        if (Control_Register !== 8'h9B) begin
            errors++;
            $display("FAIL restrobe_first: got %h expected 9b", Control_Register);
        end
        WRITE = 1'b1;
        tick(1);
        bus_write(8'd148);
        tick(1);
        checks++;
        if (Control_Register !== 8'h94) begin
            errors++;
            $display("FAIL restrobe_second: got %h expected 94", Control_Register);
        end
        checks++;
        if (dec !== 7'b00_1_0_1_0_0) begin
            errors++;
            $display("FAIL restrobe_decode_94: got %b expected 0010100", dec);
        end
        WRITE = 1'b1;
        tick(1);
        bus_write(8'hE5);
        tick(1);
        checks++;
        if (dec !== 7'b11_0_0_1_0_1) begin
            errors++;
            $display("FAIL decode_e5: got %b expected 1100101", dec);
        end
        bus_idle();
        tick(1);
    endtask

    task automatic test_reset_mid_strobe();
        bus_write(8'h80);
        tick(2);
        checks++;
        if (Control_Register !== 8'h80) begin
            errors++;
            $display("FAIL mid_pre: got %h expected 80", Control_Register);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (Control_Register !== 8'h9B) begin
            errors++;
            $display("FAIL mid_async_reset: got %h expected 9b", Control_Register);
        end
        tick(2);
        checks++;
        if (Control_Register !== 8'h9B) begin
            errors++;
            $display("FAIL mid_reset_hold: got %h expected 9b", Control_Register);
        end
        rst_n = 1'b1;
        tick(1);
        checks++;
        if (Control_Register !== 8'h80) begin
            errors++;
            $display("FAIL mid_release_accept: got %h expected 80", Control_Register);
        end
        bus_idle();
        tick(1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mode_write();
        test_bsr();
        test_gating();
        test_back_to_back();
        test_reset_mid_strobe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppi_control_register.md
Name: ppi_control_register

Overview:
- Control-word register of the 8255-style PPI.
- Captures the 8-bit control word written to address 3 and holds it for the port blocks (A, B, C).
- Decodes the held word into group mode and direction fields.
- Decodes bit-set/reset (BSR) words into a one-cycle port-C pulse; BSR words never alter the stored word.

Parameters:
- RESET_WORD, 8'h9B, control word loaded on reset (mode 0, all ports input).

Ports:
- clk  input  1  system clock, rising edge active
- rst_n  input  1  reset, asynchronous, active-low
- A  input  2  port/register select; 2'b11 selects the control register
- WRITE  input  1  write strobe, active-low
- READ  input  1  read strobe, active-low
- DATA  input  8  data bus from CPU
- Control_Register  output  8  currently held control word
- grp_a_mode  output  2  Control_Register[6:5]
- port_a_in  output  1  Control_Register[4]; 1 = port A input
- port_cu_in  output  1  Control_Register[3]; 1 = PC7..4 input
- grp_b_mode  output  1  Control_Register[2]
- port_b_in  output  1  Control_Register[1]
- port_cl_in  output  1  Control_Register[0]
- bsr_valid  output  1  one-cycle pulse on an accepted BSR word
- bsr_bit  output  3  port C bit index, DATA[3:1] of the BSR word
- bsr_value  output  1  set (1) or reset (0), DATA[0] of the BSR word

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (`rst_n`=0, asynchronous): Control_Register=RESET_WORD (8'h9B); bsr_valid=0; bsr_bit=0; bsr_value=0; write-edge history cleared to "not writing".
- Write condition: wr_sel = (A==2'b11) && (WRITE==0) && (READ==1).
- wr_sel is registered each clock into wr_sel_d.
- Accepted write: wr_sel && !wr_sel_d, i.e. the first clk edge of a strobe. A held strobe produces exactly one accept.
- Accepted write with DATA[7]=1 (mode set): Control_Register <= DATA on that edge. Visible one cycle after the accepting edge.
- Accepted write with DATA[7]=0 (BSR):
  - Control_Register is unchanged.
  - bsr_valid=1 for exactly one cycle.
  - bsr_bit=DATA[3:1], bsr_value=DATA[0]; both hold until the next BSR.
  - DATA[6:4] are ignored.
- Both strobes low (READ==0 && WRITE==0): illegal. No write is accepted and no state changes.
- A != 3 with WRITE low: writes addressed to ports A/B/C are ignored by this block.
- READ alone (A==3, READ=0): no effect. The control register is write-only on the bus, but Control_Register is always driven internally.
- DATA changing while a strobe is held: no effect after the accepting edge.
- A new write requires WRITE (or the A match) to deassert for at least one clk.
- Decode outputs are purely combinational from Control_Register.
- Reset asserted mid-strobe: reset wins. After release, a still-held strobe is treated as a new strobe and is accepted on the first clk edge.

Optional Feature:
- Macro PPI_CTRL_BSR_EN.
- Defined: BSR decode as above.
- Undefined: words with DATA[7]=0 are ignored entirely. bsr_valid, bsr_bit and bsr_value are tied to 0. Mode-set words behave identically in both builds.

Test Plan:
- Reset: rst_n=0 with clk stopped -> Control_Register=8'h9B immediately; port_a_in=1, port_b_in=1, port_cu_in=1, port_cl_in=1, grp_a_mode=0, grp_b_mode=0.
- Mode write: A=3, READ=1, WRITE=0, DATA=8'h80 -> next cycle Control_Register=8'h80, all *_in=0. Holding the strobe 5 cycles with DATA changed to 8'hA4 keeps 8'h80.
- BSR: A=3, READ=1, WRITE=0, DATA=8'd14 (0000_1110) -> Control_Register unchanged; one-cycle bsr_valid; bsr_bit=7, bsr_value=0. With the macro undefined, no pulse.
- Address/strobe gating:
  - A=2, DATA=8'd16, WRITE=0 -> no change.
  - A=0, READ=0, WRITE=0 -> no change.
  - A=3, READ=0, WRITE=0 -> no change.
- Re-strobe: write 8'h9B, release WRITE one cycle, write DATA=8'd148 (8'h94) at A=3 -> Control_Register=8'h94, grp_a_mode=0, port_a_in=1, port_cu_in=0, port_b_in=0.
- Reset mid-operation: assert rst_n=0 while a write of 8'h80 is held -> 8'h9B. Release with the strobe still low -> 8'h80 accepted on the next edge.
